// File: rtl/seg_scan_driver.sv
// seg_scan_driver: snapshots N_DIGITS nibbles once per frame and time-multiplexes them onto a
// common-anode seven-segment bank with a blank guard at the start of every digit slot.
// Latency: an/seg/dp registered, one cycle behind cnt/idx. No backpressure; en low freezes the scan.
// Optional feature macro: SEG_LEADING_ZERO_BLANK_EN (suppress leading zeros on digits >= 1).
module seg_scan_driver #(
  parameter int N_DIGITS = 6,
  parameter int DIV      = 100_000,
  parameter int W_DIV    = 17,
  parameter int BLANK    = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     en,
  input  logic [N_DIGITS-1:0][3:0] raw_segs,
  input  logic [N_DIGITS-1:0]      dp_in,
  output logic [N_DIGITS-1:0]      an,
  output logic [6:0]               seg,
  output logic                     dp,
  output logic                     frame_done
);

  localparam int               W_IDX     = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [W_DIV-1:0] CNT_MAX   = W_DIV'(DIV - 1);
  localparam logic [W_DIV-1:0] CNT_BLANK = W_DIV'(BLANK);
  localparam logic [W_IDX-1:0] IDX_MAX   = W_IDX'(N_DIGITS - 1);

  // Scan position and per-frame snapshot of the inputs.
  logic [W_DIV-1:0]          cnt_q, cnt_d;
  logic [W_IDX-1:0]          idx_q, idx_d;
  logic [N_DIGITS-1:0][3:0]  sh_val_q, sh_val_d;
  logic [N_DIGITS-1:0]       sh_dp_q, sh_dp_d;

  // Registered pin drives.
  logic [N_DIGITS-1:0]       an_q, an_d;
  logic [6:0]                seg_q, seg_d;
  logic                      dp_q, dp_d;
  logic                      frame_done_q, frame_done_d;

  logic                      tick;
  logic                      lit;
  logic [N_DIGITS-1:0]       lz_blank;

  // Hex nibble to active-low gfedcba pattern.
  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic zero_run;

  // A digit >= 1 is blanked while it and every more-significant shadow digit is zero.
  always_comb begin
    lz_blank = '0;
    zero_run = 1'b1;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      zero_run    = zero_run && (sh_val_q[k] == 4'h0);
      lz_blank[k] = zero_run;
    end
  end
`else
  assign lz_blank = '0;
`endif

  // Prescaler, digit index and frame reload of the shadow registers.
  always_comb begin
    tick         = en && (cnt_q == CNT_MAX);
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    sh_val_d     = sh_val_q;
    sh_dp_d      = sh_dp_q;
    frame_done_d = 1'b0;
    if (tick) begin
      cnt_d = '0;
      if (idx_q == IDX_MAX) begin
        idx_d        = '0;
        sh_val_d     = raw_segs;
        sh_dp_d      = dp_in;
        frame_done_d = 1'b1;
      end else begin
        idx_d = idx_q + W_IDX'(1);
      end
    end else if (en) begin
      cnt_d = cnt_q + W_DIV'(1);
    end
  end

  // Pin drives for the current slot: dark during the guard interval or when disabled.
  always_comb begin
    lit   = en && (cnt_q >= CNT_BLANK) && !lz_blank[idx_q];
    an_d  = '1;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (lit) begin
      an_d  = ~(N_DIGITS'(1) << idx_q);
      seg_d = seg_decode(sh_val_q[idx_q]);
      dp_d  = ~sh_dp_q[idx_q];
    end
  end

  // State and output registers; reset blanks the bank immediately.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      sh_val_q     <= '0;
      sh_dp_q      <= '0;
      an_q         <= '1;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      sh_val_q     <= sh_val_d;
      sh_dp_q      <= sh_dp_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: drives seg_scan_driver (N=6, DIV=4, BLANK=1) with directed and random
// stimulus; a frame-position model predicts an/seg/dp/frame_done every cycle.
// Honours SEG_LEADING_ZERO_BLANK_EN the same way the design does.
module tb_seg_scan_driver;

  localparam int N     = 6;
  localparam int DIV   = 4;
  localparam int BLANK = 1;
  localparam int W_DIV = 2;
  localparam int FRAME = N * DIV;

  logic              clk    = 1'b0;
  logic              resetn = 1'b1;
  logic              en     = 1'b0;
  logic [N-1:0][3:0] raw_segs = '0;
  logic [N-1:0]      dp_in  = '0;
  logic [N-1:0]      an;
  logic [6:0]        seg;
  logic              dp;
  logic              frame_done;

  int checks   = 0;
  int failures = 0;
  bit chk_on   = 1'b0;

  // Model: position within the frame counted in enabled cycles, plus the captured frame.
  int          pos;
  int          m_val[N];
  bit          m_dp[N];
  int          m_slot;
  int          m_phase;
  bit          m_lit;
  logic [N-1:0] e_an;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic        e_fd;
  bit [6:0]    seg_tab[16];

  seg_scan_driver #(
    .N_DIGITS(N),
    .DIV(DIV),
    .W_DIV(W_DIV),
    .BLANK(BLANK)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .en(en),
    .raw_segs(raw_segs),
    .dp_in(dp_in),
    .an(an),
    .seg(seg),
    .dp(dp),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    seg_tab[0]  = 7'h40; seg_tab[1]  = 7'h79; seg_tab[2]  = 7'h24; seg_tab[3]  = 7'h30;
    seg_tab[4]  = 7'h19; seg_tab[5]  = 7'h12; seg_tab[6]  = 7'h02; seg_tab[7]  = 7'h78;
    seg_tab[8]  = 7'h00; seg_tab[9]  = 7'h10; seg_tab[10] = 7'h08; seg_tab[11] = 7'h03;
    seg_tab[12] = 7'h46; seg_tab[13] = 7'h21; seg_tab[14] = 7'h06; seg_tab[15] = 7'h0E;
  end

  function automatic bit lz(int k);
`ifdef SEG_LEADING_ZERO_BLANK_EN
    if (k == 0) return 1'b0;
    for (int j = k; j < N; j++) if (m_val[j] != 0) return 1'b0;
    return 1'b1;
`else
    return (k < 0);
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fd(input string name, output int n);
    n = 0;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (frame_done === 1'b1) begin
        n = i;
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL %s: frame_done not seen within 60 cycles", name);
  endtask

  // Model update: outputs after an edge depend on the position seen before it.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pos = 0;
      for (int i = 0; i < N; i++) begin
        m_val[i] = 0;
        m_dp[i]  = 1'b0;
      end
      e_an  = '1;
      e_seg = 7'h7F;
      e_dp  = 1'b1;
      e_fd  = 1'b0;
    end else begin
      m_slot  = pos / DIV;
      m_phase = pos % DIV;
      m_lit   = en && (m_phase >= BLANK) && !lz(m_slot);
      for (int i = 0; i < N; i++) e_an[i] = !(m_lit && (i == m_slot));
      e_seg = m_lit ? seg_tab[m_val[m_slot]] : 7'h7F;
      e_dp  = m_lit ? !m_dp[m_slot] : 1'b1;
      e_fd  = en && (pos == FRAME - 1);
      if (en) begin
        if (pos == FRAME - 1) begin
          for (int i = 0; i < N; i++) begin
            m_val[i] = int'(raw_segs[i]);
            m_dp[i]  = dp_in[i];
          end
          pos = 0;
        end else begin
          pos = pos + 1;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      check("an", 32'(an), 32'(e_an));
      check("seg", 32'(seg), 32'(e_seg));
      check("dp", 32'(dp), 32'(e_dp));
      check("frame_done", 32'(frame_done), 32'(e_fd));
    end
  end

  task automatic lz_case(input string name, input logic [23:0] v,
                         input logic [5:0] exp_mask, input logic [6:0] exp_seg0);
    logic [5:0] mask;
    logic [6:0] s0;
    int n;
    raw_segs = v;
    dp_in    = '0;
    wait_fd({name, "_reload"}, n);
    wait_fd({name, "_reload2"}, n);
    mask = '0;
    s0   = 7'h7F;
    for (int t = 0; t < FRAME; t++) begin
      step();
      mask = mask | ~an;
      if (an == 6'b111110) s0 = seg;
    end
    check({name, "_lit_mask"}, 32'(mask), 32'(exp_mask));
    check({name, "_seg0"}, 32'(s0), 32'(exp_seg0));
  endtask

  logic [5:0] an_log[13];
  logic [6:0] seg_log[13];
  logic       dp_log[13];

  initial begin
    int n;
    int lit_cnt;
    bit found;

    // Reset
    #1 resetn = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_an", 32'(an), 32'h3F);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_dp", 32'(dp), 32'h1);
    check("rst_fd", 32'(frame_done), 32'h0);
    chk_on   = 1'b1;
    raw_segs = 24'h543210;
    dp_in    = 6'b000100;
    en       = 1'b1;
    resetn   = 1'b1;

    wait_fd("first_fd", n);
    check("first_fd_cycles", 32'(n), 32'd24);

    // Scan pattern of the first reloaded frame
    for (int t = 1; t <= 12; t++) begin
      step();
      an_log[t]  = an;
      seg_log[t] = seg;
      dp_log[t]  = dp;
    end
    check("slot0_guard_an", 32'(an_log[1]), 32'h3F);
    lit_cnt = 0;
    for (int t = 1; t <= 4; t++) if (an_log[t] == 6'b111110) lit_cnt++;
    check("slot0_lit_cycles", 32'(lit_cnt), 32'd3);
    check("slot0_seg", 32'(seg_log[2]), 32'h40);
    check("slot1_seg", 32'(seg_log[6]), 32'h79);
    check("slot1_dp", 32'(dp_log[6]), 32'h1);
    check("slot2_guard_an", 32'(an_log[9]), 32'h3F);
    check("slot2_an", 32'(an_log[10]), 32'(6'b111011));
    check("slot2_seg", 32'(seg_log[10]), 32'h24);
    check("slot2_dp", 32'(dp_log[10]), 32'h0);

    // Tear-free update
    raw_segs[0] = 4'h8;
    wait_fd("tear_reload8", n);
    raw_segs[0] = 4'h1;
    step();
    step();
    check("tear_old_an", 32'(an), 32'(6'b111110));
    check("tear_old_seg", 32'(seg), 32'h00);
    wait_fd("tear_reload1", n);
    step();
    step();
    check("tear_new_seg", 32'(seg), 32'h79);

    // Enable gating at idx=3, cnt=2
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (pos == 3 * DIV + 2) found = 1'b1;
      else step();
    end
    check("en_pos_found", 32'(found), 32'h1);
    en = 1'b0;
    step();
    check("en_off_an", 32'(an), 32'h3F);
    repeat (9) step();
    en = 1'b1;
    step();
    check("en_resume_an0", 32'(an), 32'(6'b110111));
    step();
    check("en_resume_an1", 32'(an), 32'(6'b110111));
    step();
    check("en_resume_guard", 32'(an), 32'h3F);
    step();
    check("en_next_slot_an", 32'(an), 32'(6'b101111));

    // Async reset mid-scan
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (an == 6'b110111) found = 1'b1;
    end
    check("arst_an_found", 32'(found), 32'h1);
    #2 resetn = 1'b0;
    #1;
    check("arst_an", 32'(an), 32'h3F);
    check("arst_seg", 32'(seg), 32'h7F);
    check("arst_dp", 32'(dp), 32'h1);
    check("arst_fd", 32'(frame_done), 32'h0);
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    step();
    check("arst_restart_guard", 32'(an), 32'h3F);
    step();
    check("arst_restart_an", 32'(an), 32'(6'b111110));
    check("arst_restart_seg", 32'(seg), 32'h40);

    // Leading-zero behaviour
`ifdef SEG_LEADING_ZERO_BLANK_EN
    lz_case("lz_7", 24'h000007, 6'b000001, 7'h78);
    lz_case("lz_zero", 24'h000000, 6'b000001, 7'h40);
    lz_case("lz_1000", 24'h001000, 6'b001111, 7'h40);
`else
    lz_case("lz_7", 24'h000007, 6'b111111, 7'h78);
    lz_case("lz_zero", 24'h000000, 6'b111111, 7'h40);
    lz_case("lz_1000", 24'h001000, 6'b111111, 7'h40);
`endif

    // Random phase: data, decimal points and enable vary; model checks each cycle
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        for (int i = 0; i < N; i++)
          raw_segs[i] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        dp_in = 6'($urandom);
      end
      en = ($urandom_range(0, 9) != 0);
      step();
    end
    en = 1'b1;
    repeat (FRAME + 2) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
